// File: rtl/data_memory.sv
// data_memory: byte-addressed data memory for the load/store stage of the
// 8-bit single-cycle CPU datapath. Writes land on the rising CLK edge.
// Reads are combinational and gated by memread. An asynchronous active-low
// RESET clears every location to zero.
module data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  memread,
  input  logic                  memwrite,
  output logic [DATA_WIDTH-1:0] readdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage array. It is built from flops so that the whole array can be
  // cleared asynchronously in one step.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Read mux output before the memread gate.
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Storage update: asynchronous clear on reset, synchronous write when enabled.
  // Because reset has priority, a write that is pending while RESET is low is dropped.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (memwrite) begin
      mem_r[address] <= writedata;
    end
  end

  // Combinational read: zero latency. The output is forced to zero unless memread is set.
  always_comb begin
    rd_word_s = mem_r[address];
    if (memread) begin
      readdata = rd_word_s;
    end else begin
      readdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. A reference array models the memory.
// Each read pushes its expected value onto a scoreboard queue, and the value
// is popped and compared once the combinational output has settled.
`timescale 1ns/100ps
module tb_data_memory;

  logic       CLK;
  logic       RESET;
  logic [7:0] address;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] readdata;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  int         checks;
  int         failures;

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .address   (address),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .readdata  (readdata)
  );

  // 50 ns clock period. Rising edges fall at 25, 75, 125 ns and so on.
  initial CLK = 1'b0;
  always #25 CLK = ~CLK;

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // Combinational read: queue the expectation, let the output settle, then compare.
  task automatic read_mem(input string tag, input logic [7:0] a, input logic rd);
    address = a;
    memread = rd;
    exp_q.push_back(rd ? model[a] : 8'h00);
    #1;
    check_val(tag, readdata, exp_q.pop_front());
  endtask

  // One clocked write. Inputs are set up in the low phase, then the
  // rising edge commits the write.
  task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    address   = a;
    writedata = d;
    memwrite  = 1'b1;
    memread   = 1'b0;
    @(posedge CLK);
    if (RESET) model[a] = d;
    #1;
    memwrite = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RESET     = 1'b1;
    address   = 8'h00;
    writedata = 8'h00;
    memread   = 1'b0;
    memwrite  = 1'b0;
    clear_model();

    // Power-up reset: sweep every address while RESET is held low.
    #2;
    RESET   = 1'b0;
    memread = 1'b1;
    clear_model();
    for (int a = 0; a < 256; a++) begin
      read_mem("rst_sweep", 8'(a), 1'b1);
    end
    #3;
    RESET = 1'b1;
    read_mem("rst_release", 8'h10, 1'b1);
    read_mem("rst_release_ff", 8'hFF, 1'b1);

    // Basic write followed by a read before the next edge.
    write_mem(8'h10, 8'hA5);
    read_mem("basic_rd", 8'h10, 1'b1);

    // Boundary addresses and the memread gate.
    write_mem(8'hFF, 8'h3C);
    write_mem(8'h00, 8'h5A);
    read_mem("gate_off_ff", 8'hFF, 1'b0);
    read_mem("gate_off_00", 8'h00, 1'b0);
    read_mem("bound_ff", 8'hFF, 1'b1);
    read_mem("bound_00", 8'h00, 1'b1);
    read_mem("bound_10", 8'h10, 1'b1);

    // Write disabled: the data bus toggles, but the array must not change.
    @(negedge CLK);
    address   = 8'h10;
    writedata = 8'hFF;
    memwrite  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    read_mem("wr_disabled", 8'h10, 1'b1);

    // Same-cycle read and write at the same address.
    @(negedge CLK);
    address   = 8'h20;
    writedata = 8'h77;
    memread   = 1'b1;
    memwrite  = 1'b1;
    #1;
    exp_q.push_back(model[8'h20]);
    check_val("rw_before", readdata, exp_q.pop_front());
    @(posedge CLK);
    model[8'h20] = 8'h77;
    #1;
    exp_q.push_back(model[8'h20]);
    check_val("rw_after", readdata, exp_q.pop_front());
    memwrite = 1'b0;

    // Asynchronous reset in the middle of a write.
    write_mem(8'h01, 8'h11);
    write_mem(8'h02, 8'h22);
    write_mem(8'h03, 8'h33);
    write_mem(8'h04, 8'h44);
    read_mem("fill_01", 8'h01, 1'b1);
    read_mem("fill_04", 8'h04, 1'b1);
    @(negedge CLK);
    #5;
    address   = 8'h01;
    writedata = 8'hEE;
    memread   = 1'b1;
    memwrite  = 1'b1;
    #5;
    RESET = 1'b0;
    clear_model();
    read_mem("rst_immediate", 8'h01, 1'b1);
    @(posedge CLK);
    #1;
    read_mem("rst_hold_wr", 8'h01, 1'b1);
    #5;
    memwrite = 1'b0;
    #5;
    RESET = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      read_mem("rst_cleared", 8'(a), 1'b1);
    end
    read_mem("rst_cleared_10", 8'h10, 1'b1);
    read_mem("rst_cleared_20", 8'h20, 1'b1);

    // Confirm that writes work again after reset is released.
    write_mem(8'h04, 8'hC3);
    read_mem("post_rst_wr", 8'h04, 1'b1);
    read_mem("post_rst_nb", 8'h03, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
